// File: rtl/address_sequencer_pkg.sv
// Shared types for the address sequencer: addressing modes and controller states.
package address_sequencer_pkg;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    LFSR   = 2'b01,
    WRAP   = 2'b10
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The unused encoding 2'b11 behaves as LINEAR.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = LFSR;
      2'b10:   m = WRAP;
      default: m = LINEAR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// One Galois LFSR step under a state mask; an all-zero result is forced to 1
// so the register can never lock up.
module galois_lfsr_step #(
  parameter int ADDRESS_WIDTH = 48
) (
  input  logic [ADDRESS_WIDTH-1:0] state_in,
  input  logic [ADDRESS_WIDTH-1:0] taps,
  input  logic [ADDRESS_WIDTH-1:0] mask,
  output logic [ADDRESS_WIDTH-1:0] state_out
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH-1:0] shifted;

  always_comb begin
    shifted   = ((state_in >> 1) ^ (state_in[0] ? taps : '0)) & mask;
    state_out = (shifted == '0) ? ONE : shifted;
  end

endmodule

// File: rtl/address_sequencer.sv
// Address generator emitting transfer_count addresses in LINEAR, WRAP or LFSR
// order over a valid/ready handshake, with a one-cycle done pulse at the end.
//
// state | meaning
// IDLE  | waiting for start; done may pulse for one cycle after a sequence
// RUN   | address_valid high, advancing on each accepted address
module address_sequencer
  import address_sequencer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 48,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [ADDRESS_WIDTH-1:0] range_start,
  input  logic [ADDRESS_WIDTH-1:0] range_increment,
  input  logic [ADDRESS_WIDTH-1:0] range_limit,
  input  logic [ADDRESS_WIDTH-1:0] lfsr_seed,
  input  logic [ADDRESS_WIDTH-1:0] lfsr_taps,
  input  logic [ADDRESS_WIDTH-1:0] lfsr_mask,
  input  logic [ADDRESS_WIDTH-1:0] final_mask,
  input  logic [COUNT_WIDTH-1:0]   transfer_count,
  output logic                     address_valid,
  input  logic                     address_ready,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   count_remaining
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [ADDRESS_WIDTH-1:0] start_q, start_d;
  logic [ADDRESS_WIDTH-1:0] inc_q, inc_d;
  logic [ADDRESS_WIDTH-1:0] limit_q, limit_d;
  logic [ADDRESS_WIDTH-1:0] taps_q, taps_d;
  logic [ADDRESS_WIDTH-1:0] lmask_q, lmask_d;
  logic [ADDRESS_WIDTH-1:0] fmask_q, fmask_d;
  logic [ADDRESS_WIDTH-1:0] cur_q, cur_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     done_q, done_d;

  logic [ADDRESS_WIDTH:0]   sum;
  logic [ADDRESS_WIDTH-1:0] lfsr_next;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [ADDRESS_WIDTH-1:0] seed_load;
  mode_e                    mode_in;

  galois_lfsr_step #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_lfsr_step (
    .state_in  (cur_q),
    .taps      (taps_q),
    .mask      (lmask_q),
    .state_out (lfsr_next)
  );

  always_comb begin
    sum       = {1'b0, cur_q} + {1'b0, inc_q};
    next_addr = sum[ADDRESS_WIDTH-1:0];
    case (mode_q)
      LFSR: next_addr = lfsr_next;
      // Carry-out or passing the inclusive limit both fold back to the start.
      WRAP: if (sum[ADDRESS_WIDTH] || (sum[ADDRESS_WIDTH-1:0] > limit_q)) next_addr = start_q;
      default: next_addr = sum[ADDRESS_WIDTH-1:0];
    endcase
  end

  always_comb begin
    mode_in   = decode_mode(mode);
    seed_load = lfsr_seed & lfsr_mask;
    if (seed_load == '0) seed_load = ONE;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = start_q;
    inc_d   = inc_q;
    limit_d = limit_q;
    taps_d  = taps_q;
    lmask_d = lmask_q;
    fmask_d = fmask_q;
    cur_d   = cur_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (transfer_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            mode_d  = mode_in;
            start_d = range_start;
            inc_d   = range_increment;
            limit_d = range_limit;
            taps_d  = lfsr_taps;
            lmask_d = lfsr_mask;
            fmask_d = final_mask;
            count_d = transfer_count;
            cur_d   = (mode_in == LFSR) ? seed_load : range_start;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (address_ready) begin
          cur_d   = next_addr;
          count_d = count_q - COUNT_WIDTH'(1);
          if (count_q == COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= LINEAR;
      start_q <= '0;
      inc_q   <= '0;
      limit_q <= '0;
      taps_q  <= '0;
      lmask_q <= '0;
      fmask_q <= '0;
      cur_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      inc_q   <= inc_d;
      limit_q <= limit_d;
      taps_q  <= taps_d;
      lmask_q <= lmask_d;
      fmask_q <= fmask_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign address_valid   = (state_q == RUN);
  assign busy            = (state_q == RUN);
  assign address         = cur_q & fmask_q;
  assign done            = done_q;
  assign count_remaining = count_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: a queue-based model of the emitted sequence,
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_address_sequencer;

  localparam int AW = 16;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset, start, abort, address_ready;
  logic [1:0]    mode;
  logic [AW-1:0] range_start, range_increment, range_limit;
  logic [AW-1:0] lfsr_seed, lfsr_taps, lfsr_mask, final_mask;
  logic [CW-1:0] transfer_count;
  logic          address_valid, busy, done;
  logic [AW-1:0] address;
  logic [CW-1:0] count_remaining;

  int total = 0;
  int bad   = 0;

  address_sequencer #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .range_start(range_start), .range_increment(range_increment),
    .range_limit(range_limit), .lfsr_seed(lfsr_seed), .lfsr_taps(lfsr_taps),
    .lfsr_mask(lfsr_mask), .final_mask(final_mask),
    .transfer_count(transfer_count), .address_valid(address_valid),
    .address_ready(address_ready), .address(address), .busy(busy),
    .done(done), .count_remaining(count_remaining)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: on start the whole expected address list is computed from the
  // configuration; each accepted address pops one entry.
  logic [AW-1:0] m_q[$];
  bit            m_run, m_done;
  int            m_count;
  logic [AW-1:0] m_fmask;

  task automatic build_sequence(input int n);
    logic [AW-1:0] a;
    int            s;
    m_q.delete();
    case (mode)
      2'b01: begin
        a = lfsr_seed & lfsr_mask;
        if (a == 0) a = 1;
        for (int i = 0; i < n; i++) begin
          m_q.push_back(a);
          a = ((a >> 1) ^ (a[0] ? lfsr_taps : 16'h0)) & lfsr_mask;
          if (a == 0) a = 1;
        end
      end
      2'b10: begin
        a = range_start;
        for (int i = 0; i < n; i++) begin
          m_q.push_back(a);
          s = int'(a) + int'(range_increment);
          a = (s > int'(range_limit)) ? range_start : AW'(s);
        end
      end
      default: begin
        for (int i = 0; i < n; i++)
          m_q.push_back(AW'(int'(range_start) + i * int'(range_increment)));
      end
    endcase
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_count = 0; m_q.delete();
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start) begin
          if (transfer_count == 0) m_done = 1;
          else begin
            build_sequence(int'(transfer_count));
            m_count = int'(transfer_count);
            m_fmask = final_mask;
            m_run   = 1;
          end
        end
      end else if (abort) begin
        m_run = 0; m_count = 0; m_q.delete();
      end else if (address_ready) begin
        void'(m_q.pop_front());
        m_count--;
        if (m_count == 0) begin m_run = 0; m_done = 1; end
      end
    end
  end

  logic [AW-1:0] got[$];
  logic [AW-1:0] exp_q[$];
  int            done_cnt  = 0;
  int            valid_cnt = 0;

  always @(negedge clock) begin
    check("valid", address_valid, m_run);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("count", count_remaining, m_count);
    if (m_run && m_q.size() > 0) check("address", address, m_q[0] & m_fmask);
    if (address_valid) valid_cnt++;
    if (address_valid && address_ready && !abort) got.push_back(address);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic configure(input logic [1:0] md, input logic [AW-1:0] rs, ri, rl,
                           input logic [AW-1:0] sd, tp, lm, fm, input logic [CW-1:0] tc);
    mode = md; range_start = rs; range_increment = ri; range_limit = rl;
    lfsr_seed = sd; lfsr_taps = tp; lfsr_mask = lm; final_mask = fm;
    transfer_count = tc;
  endtask

  task automatic go();
    got.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL %s: timeout, busy got 1 expected 0", name);
    end
    tick();
  endtask

  task automatic check_got(input string name);
    check({name, "_len"}, got.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got.size()) check(name, got[i], exp_q[i]);
  endtask

  int d0, v0;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; address_ready = 1'b1;
    configure(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_address", address, 0);
    check("rst_valid", address_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count_remaining, 0);
    reset = 1'b0;
    tick();

    // LINEAR
    d0 = done_cnt;
    configure(2'b00, 16'h0100, 16'h0010, 16'h0, 0, 0, 0, 16'hFFFF, 3);
    go(); wait_idle("lin");
    exp_q = '{16'h0100, 16'h0110, 16'h0120};
    check_got("lin_addr");
    check("lin_done_pulses", done_cnt - d0, 1);

    // WRAP
    configure(2'b10, 16'h0010, 16'h0004, 16'h0018, 0, 0, 0, 16'hFFFF, 5);
    go(); wait_idle("wrap");
    exp_q = '{16'h0010, 16'h0014, 16'h0018, 16'h0010, 16'h0014};
    check_got("wrap_addr");

    // WRAP with carry-out of the 16-bit sum
    configure(2'b10, 16'hFFF0, 16'h0008, 16'hFFFF, 0, 0, 0, 16'hFFFF, 4);
    go(); wait_idle("wrapc");
    exp_q = '{16'hFFF0, 16'hFFF8, 16'hFFF0, 16'hFFF8};
    check_got("wrap_carry_addr");

    // LFSR
    configure(2'b01, 0, 0, 0, 16'h0001, 16'h00B8, 16'h00FF, 16'h00FF, 3);
    go(); wait_idle("lfsr");
    exp_q = '{16'h0001, 16'h00B8, 16'h005C};
    check_got("lfsr_addr");

    configure(2'b01, 0, 0, 0, 16'h0000, 16'h00B8, 16'h00FF, 16'h00FF, 2);
    go(); wait_idle("lfsr0");
    exp_q = '{16'h0001, 16'h00B8};
    check_got("lfsr_zero_seed");

    // Mode 11 behaves as LINEAR; final_mask clears the low nibble
    configure(2'b11, 16'h0107, 16'h0010, 0, 0, 0, 0, 16'hFFF0, 2);
    go(); wait_idle("mode3");
    exp_q = '{16'h0100, 16'h0110};
    check_got("mode3_mask");

    // Backpressure; inputs changed and start re-asserted mid-run
    configure(2'b00, 16'h0200, 16'h0003, 0, 0, 0, 0, 16'hFFFF, 5);
    go(); tick();
    address_ready = 1'b0; range_increment = 16'h0055; mode = 2'b01; start = 1'b1;
    tick(); tick(); tick();
    check("bp_address", address, 16'h0203);
    check("bp_count", count_remaining, 4);
    check("bp_valid", address_valid, 1);
    address_ready = 1'b1; start = 1'b0;
    wait_idle("bp");
    exp_q = '{16'h0200, 16'h0203, 16'h0206, 16'h0209, 16'h020C};
    check_got("bp_addr");

    // Abort with a simultaneous handshake at count 2
    d0 = done_cnt;
    configure(2'b00, 16'h0300, 16'h0001, 0, 0, 0, 0, 16'hFFFF, 4);
    go(); tick(); tick();
    check("abort_pre_count", count_remaining, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_count", count_remaining, 0);
    tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);
    exp_q = '{16'h0300, 16'h0301};
    check_got("abort_addr");

    // transfer_count 0 with abort in IDLE (ignored)
    d0 = done_cnt; v0 = valid_cnt;
    configure(2'b00, 16'h0400, 16'h0001, 0, 0, 0, 0, 16'hFFFF, 0);
    abort = 1'b1;
    go();
    abort = 1'b0;
    tick(); tick();
    check("zero_done", done_cnt - d0, 1);
    check("zero_no_valid", valid_cnt - v0, 0);

    // Asynchronous reset mid-RUN
    d0 = done_cnt;
    configure(2'b00, 16'h0500, 16'h0001, 0, 0, 0, 0, 16'hFFFF, 10);
    go(); tick();
    #1 reset = 1'b1;
    #1;
    check("mrst_address", address, 0);
    check("mrst_valid", address_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_count", count_remaining, 0);
    check("mrst_done", done, 0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("mrst_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/address_sequencer.md
ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 The block SHALL have these parameters:
  ADDRESS_WIDTH, 48, width of all address, seed, tap and mask signals.
  COUNT_WIDTH, 32, width of transfer_count and count_remaining.
REQ-002 The block SHALL have these ports:
  clock  input  1  single clock, rising edge.
  reset  input  1  asynchronous, active-high reset.
  start  input  1  start pulse; sampled only in IDLE.
  abort  input  1  terminate a running sequence.
  mode  input  2  00 LINEAR, 01 LFSR, 10 WRAP, 11 is treated as LINEAR.
  range_start  input  ADDRESS_WIDTH  first address in LINEAR and WRAP modes.
  range_increment  input  ADDRESS_WIDTH  step in LINEAR and WRAP modes.
  range_limit  input  ADDRESS_WIDTH  inclusive upper bound in WRAP mode.
  lfsr_seed  input  ADDRESS_WIDTH  initial LFSR state.
  lfsr_taps  input  ADDRESS_WIDTH  Galois tap mask.
  lfsr_mask  input  ADDRESS_WIDTH  mask applied to every LFSR state.
  final_mask  input  ADDRESS_WIDTH  mask applied to the output address.
  transfer_count  input  COUNT_WIDTH  number of addresses to emit.
  address_valid  output  1  address is presented.
  address_ready  input  1  consumer accepts the address.
  address  output  ADDRESS_WIDTH  generated address.
  busy  output  1  high while in RUN.
  done  output  1  one-cycle completion pulse.
  count_remaining  output  COUNT_WIDTH  number of addresses not yet accepted.

Function
REQ-003 The state machine SHALL have two states, IDLE and RUN; done SHALL be a registered one-cycle pulse and SHALL NOT be a separate state.
REQ-004 In IDLE, start with transfer_count=0 SHALL pulse done in the next cycle and SHALL remain in IDLE.
REQ-005 In IDLE, start with transfer_count>0 SHALL, at the same edge: latch mode, all range/LFSR/mask inputs and transfer_count; load the current address; and enter RUN.
REQ-006 The current address SHALL load as range_start in LINEAR/WRAP mode and as lfsr_seed&lfsr_mask in LFSR mode; if that LFSR value is zero, the state SHALL load as 1.
REQ-007 address_valid SHALL be asserted in the first cycle after the start edge, giving a latency of 1.
REQ-008 In RUN, address_valid SHALL be 1, and address, address_valid and count_remaining SHALL stay stable until the handshake (address_valid & address_ready).
REQ-009 On each handshake, the current address SHALL advance and count_remaining SHALL decrement by 1.
REQ-010 LINEAR mode: next = current + range_increment, modulo 2^ADDRESS_WIDTH.
REQ-011 WRAP mode: next = range_start if the sum carries out or exceeds range_limit; otherwise next = the sum.
REQ-012 LFSR mode: next = ((current>>1) ^ (current[0] ? lfsr_taps : 0)) & lfsr_mask; a masked-to-zero result SHALL be replaced by 1.
REQ-013 The output address SHALL equal current & latched final_mask.
REQ-014 The handshake that takes count_remaining from 1 to 0 SHALL return the block to IDLE, deassert address_valid and busy in the next cycle, and pulse done in the next cycle.
REQ-015 abort in RUN SHALL return to IDLE at that edge with no done pulse and count_remaining cleared to 0; abort SHALL take priority over a simultaneous handshake.
REQ-016 start SHALL be ignored in RUN; abort SHALL be ignored in IDLE.
REQ-017 Input changes after the start edge SHALL NOT affect the running sequence.

Reset
REQ-018 Reset SHALL force: state=IDLE, address=0, address_valid=0, busy=0, done=0, count_remaining=0, all latched configuration=0.
REQ-019 Reset asserted mid-RUN SHALL take effect immediately and asynchronously, and SHALL NOT produce a done pulse.

Structure
REQ-020 A package address_sequencer_pkg SHALL hold the mode enumeration (LINEAR, LFSR, WRAP) and the state enumeration (IDLE, RUN).
REQ-021 The next-address computation for LFSR mode SHALL be a combinational sub-module named galois_lfsr_step, parametrised by ADDRESS_WIDTH.

Verification
REQ-022 LINEAR, W=16, range_start 0x0100, range_increment 0x0010, transfer_count 3, ready always 1 -> addresses 0x0100, 0x0110, 0x0120; done pulses one cycle after the third handshake.
REQ-023 WRAP, range_start 0x10, range_increment 0x04, range_limit 0x18, transfer_count 5 -> addresses 0x10, 0x14, 0x18, 0x10, 0x14.
REQ-024 LFSR, W=8, lfsr_seed 0x01, lfsr_taps 0xB8, lfsr_mask 0xFF, final_mask 0xFF -> addresses 0x01, 0xB8, 0x5C; lfsr_seed 0x00 -> first address 0x01.
REQ-025 Backpressure: address_ready low for 3 cycles mid-sequence -> address and count_remaining stable and address_valid held high; the sequence resumes unchanged.
REQ-026 Abort with a simultaneous handshake at count_remaining=2 -> IDLE in the next cycle, no done pulse, count_remaining=0; reset mid-RUN -> all outputs at their reset values immediately.
REQ-027 start with transfer_count=0 -> done pulse with address_valid never asserted.
